alu_exec_unit: RTL and testbench

- Execute-stage consumer of the 4-bit ALU control code emitted by the ALU-control decoder.
- Performs the selected operation on two XLEN operands behind a valid/ready handshake.
- Logic/arith/compare ops complete in 1 cycle. Shifts run serially, 1 bit per cycle, to save area.
- Exposes in_ready so the hazard unit can stall IF/ID while a shift is in flight.

---
 rtl/alu_exec_unit_pkg.sv | 29 ++
 rtl/alu_exec_unit_if.sv | 27 ++
 rtl/alu_serial_shifter.sv | 54 +++++
 rtl/alu_exec_unit.sv | 110 +++++++++++
 tb/tb_alu_exec_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared ALU op encoding, FSM states and default widths
package alu_exec_unit_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int SHAMT_W_DEF = 5;

  // One encoding shared with the ALU-control decoder
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/result handshake bundle of the execute-stage ALU
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_control, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - one-bit-per-cycle shifter; o_done flags the final step
module alu_serial_shifter
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_abort,
  input  logic               i_load,
  input  logic [1:0]         i_kind,
  input  logic [XLEN-1:0]    i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_busy,
  output logic               o_done,
  output logic [XLEN-1:0]    o_next
);

  logic [XLEN-1:0]    r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic [1:0]         r_kind;

  // i_kind is alu_control[1:0]: 00 SLL, 01 SRL, 10 SRA
  always_comb begin
    o_next = r_work;
    case (r_kind)
      2'b00:   o_next = {r_work[XLEN-2:0], 1'b0};
      2'b01:   o_next = {1'b0, r_work[XLEN-1:1]};
      default: o_next = {r_work[XLEN-1], r_work[XLEN-1:1]};
    endcase
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == SHAMT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_kind <= 2'b00;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_work <= i_data;
      r_cnt  <= i_shamt;
      r_kind <= i_kind;
    end else if (o_busy) begin
      r_work <= o_next;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU: 1-cycle logic/arith/compare, serial shifts
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  alu_exec_unit_if.slave  bus
);

  state_e             r_state;
  state_e             w_next_state;
  logic [XLEN-1:0]    r_result;
  logic               r_illegal;
  logic [XLEN-1:0]    w_alu_result;
  logic               w_alu_illegal;
  logic [XLEN-1:0]    w_sh_next;
  logic               w_sh_busy;
  logic               w_sh_done;
  logic               w_accept;
  logic               w_start_shift;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt       = bus.op_b[SHAMT_W-1:0];
  assign bus.in_ready  = !flush && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_DONE) && bus.out_ready));
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_start_shift = w_accept && is_shift(bus.alu_control) && (w_shamt != '0);

  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.zero      = (r_result == '0);
  assign bus.illegal   = r_illegal;

  // Shift codes land here only with shamt==0, where the result is op_a unchanged
  always_comb begin
    w_alu_result  = '0;
    w_alu_illegal = 1'b0;
    case (bus.alu_control)
      ALU_ADD:  w_alu_result = bus.op_a + bus.op_b;
      ALU_SUB:  w_alu_result = bus.op_a - bus.op_b;
      ALU_AND:  w_alu_result = bus.op_a & bus.op_b;
      ALU_OR:   w_alu_result = bus.op_a | bus.op_b;
      ALU_XOR:  w_alu_result = bus.op_a ^ bus.op_b;
      ALU_SLT:  w_alu_result = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_SLTU: w_alu_result = XLEN'(bus.op_a < bus.op_b);
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_result = bus.op_a;
      default:  w_alu_illegal = 1'b1;
    endcase
  end

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_abort (flush),
    .i_load  (w_start_shift),
    .i_kind  (bus.alu_control[1:0]),
    .i_data  (bus.op_a),
    .i_shamt (w_shamt),
    .o_busy  (w_sh_busy),
    .o_done  (w_sh_done),
    .o_next  (w_sh_next)
  );

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_IDLE;
    end else if (w_accept) begin
      w_next_state = w_start_shift ? ST_SHIFT : ST_DONE;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (w_sh_done)       w_next_state = ST_DONE;
          else if (!w_sh_busy) w_next_state = ST_IDLE;
        end
        ST_DONE:  if (bus.out_ready) w_next_state = ST_IDLE;
        default:  w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Result is left untouched on flush; it is don't-care while out_valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (!flush) begin
      if (w_accept && !w_start_shift) begin
        r_result  <= w_alu_result;
        r_illegal <= w_alu_illegal;
      end else if ((r_state == ST_SHIFT) && w_sh_done) begin
        r_result  <= w_sh_next;
        r_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized and directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit_if #(.XLEN(32)) bus();

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole operation at once, {illegal, result}
  function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] sa;
    sh = b % 32;
    sa = a;
    case (c)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd6:    return {1'b0, (sa < $signed(b)) ? 32'd1 : 32'd0};
      4'd7:    return {1'b0, (a < b) ? 32'd1 : 32'd0};
      4'd8:    return {1'b0, a << sh};
      4'd9:    return {1'b0, a >> sh};
      4'd10:   return {1'b0, 32'(sa >>> sh)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
    if ((c == 4'd8 || c == 4'd9 || c == 4'd10) && (b % 32) != 0) return int'(b % 32) + 1;
    return 1;
  endfunction

  // Issues one op, scrambles inputs after accept, waits (bounded) for the result, then hands it off
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic ill, output logic z,
                        output logic acc_ok, output logic busy_ok, output logic drop_ok);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = c;
    bus.op_a        = a;
    bus.op_b        = b;
    #1;
    acc_ok = bus.in_ready;
    step();
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'($urandom);
    bus.op_a        = $urandom;
    bus.op_b        = $urandom;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) busy_ok = 1'b0;
      step();
      lat++;
    end
    res = bus.result;
    ill = bus.illegal;
    z   = bus.zero;
    step();
    drop_ok = !bus.out_valid;
  endtask

  task automatic test_reset();
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.alu_control = 4'd0;
    bus.op_a        = 32'd0;
    bus.op_b        = 32'd0;
    rst = 1'b1;
    step();
    step();
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    if (bus.result !== 32'd0)   begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
    if (bus.zero !== 1'b1)      begin errors++; $display("FAIL reset_zero got %b exp 1", bus.zero); end
    if (bus.illegal !== 1'b0)   begin errors++; $display("FAIL reset_illegal got %b exp 0", bus.illegal); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    vec_t vq[$];
    int lat;
    logic [31:0] res;
    logic ill, z, acc_ok, busy_ok, drop_ok;
    vq.push_back('{4'h0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1});
    vq.push_back('{4'h1, 32'h5,        32'h5,        32'h0,        1'b0, 1});
    vq.push_back('{4'h6, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1});
    vq.push_back('{4'h7, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1});
    vq.push_back('{4'h5, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1});
    vq.push_back('{4'hF, 32'h12345678, 32'h9,        32'h0,        1'b1, 1});
    vq.push_back('{4'hA, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 5});
    vq.push_back('{4'h8, 32'h12345678, 32'h20,       32'h12345678, 1'b0, 1});
    vq.push_back('{4'h8, 32'h1,        32'h1,        32'h2,        1'b0, 2});
    vq.push_back('{4'h9, 32'h80000000, 32'h1F,       32'h1,        1'b0, 32});
    vq.push_back('{4'h2, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1});
    vq.push_back('{4'h3, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1});
    vq.push_back('{4'h4, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, 1'b0, 1});
    foreach (vq[i]) begin
      run_op(vq[i].c, vq[i].a, vq[i].b, lat, res, ill, z, acc_ok, busy_ok, drop_ok);
      checks += 7;
      if (res !== vq[i].r)   begin errors++; $display("FAIL dir%0d_result got %h exp %h", i, res, vq[i].r); end
      if (ill !== vq[i].ill) begin errors++; $display("FAIL dir%0d_illegal got %b exp %b", i, ill, vq[i].ill); end
      if (lat !== vq[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, vq[i].lat); end
      if (z !== (vq[i].r == 32'd0)) begin errors++; $display("FAIL dir%0d_zero got %b exp %b", i, z, (vq[i].r == 32'd0)); end
      if (acc_ok !== 1'b1)   begin errors++; $display("FAIL dir%0d_accept in_ready got %b exp 1", i, acc_ok); end
      if (busy_ok !== 1'b1)  begin errors++; $display("FAIL dir%0d_busy in_ready_low got %b exp 1", i, busy_ok); end
      if (drop_ok !== 1'b1)  begin errors++; $display("FAIL dir%0d_drop out_valid_cleared got %b exp 1", i, drop_ok); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] res, a, b;
    logic [3:0] c;
    logic [32:0] exp_v;
    logic ill, z, acc_ok, busy_ok, drop_ok;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exp_v = ref_op(c, a, b);
      run_op(c, a, b, lat, res, ill, z, acc_ok, busy_ok, drop_ok);
      checks += 4;
      if (res !== exp_v[31:0]) begin errors++; $display("FAIL rnd%0d_result c=%h a=%h b=%h got %h exp %h", i, c, a, b, res, exp_v[31:0]); end
      if (ill !== exp_v[32])   begin errors++; $display("FAIL rnd%0d_illegal c=%h got %b exp %b", i, c, ill, exp_v[32]); end
      if (lat !== ref_lat(c, b)) begin errors++; $display("FAIL rnd%0d_latency c=%h b=%h got %0d exp %0d", i, c, b, lat, ref_lat(c, b)); end
      if (drop_ok !== 1'b1)    begin errors++; $display("FAIL rnd%0d_drop out_valid_cleared got %b exp 1", i, drop_ok); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp_r;
    a = $urandom;
    b = $urandom;
    exp_r = a + b;
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.alu_control = ALU_ADD;
    bus.op_a        = a;
    bus.op_b        = b;
    step();
    bus.alu_control = ALU_SUB;
    bus.op_a        = $urandom;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 3;
      if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL bp%0d_in_ready got %b exp 0", i, bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid got %b exp 1", i, bus.out_valid); end
      if (bus.result !== exp_r)   begin errors++; $display("FAIL bp%0d_result got %h exp %h", i, bus.result, exp_r); end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release out_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] a, b;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      exp_q.push_back(a + b);
      bus.in_valid    = 1'b1;
      bus.alu_control = ALU_ADD;
      bus.op_a        = a;
      bus.op_b        = b;
      step();
      checks += 2;
      if (bus.out_valid !== 1'b1)   begin errors++; $display("FAIL b2b%0d_out_valid got %b exp 1", i, bus.out_valid); end
      if (bus.result !== exp_q[i])  begin errors++; $display("FAIL b2b%0d_result got %h exp %h", i, bus.result, exp_q[i]); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end out_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] res;
    logic ill, z, acc_ok, busy_ok, drop_ok, stayed_low;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = ALU_SRL;
    bus.op_a        = 32'hFFFFFFFF;
    bus.op_b        = 32'd31;
    step();
    bus.in_valid = 1'b0;
    step();
    flush = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = ALU_ADD;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL flush_idle in_ready got %b exp 1", bus.in_ready); end
    stayed_low = 1'b1;
    for (int i = 0; i < 35; i++) begin
      if (bus.out_valid) stayed_low = 1'b0;
      step();
    end
    checks++;
    if (stayed_low !== 1'b1) begin errors++; $display("FAIL flush_discard out_valid_stayed_low got %b exp 1", stayed_low); end
    run_op(ALU_AND, 32'hF0F0, 32'hFF00, lat, res, ill, z, acc_ok, busy_ok, drop_ok);
    checks += 2;
    if (res !== 32'hF000) begin errors++; $display("FAIL flush_after_and result got %h exp f000", res); end
    if (lat !== 1)        begin errors++; $display("FAIL flush_after_and latency got %0d exp 1", lat); end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    logic [31:0] res;
    logic ill, z, acc_ok, busy_ok, drop_ok;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = ALU_SLL;
    bus.op_a        = 32'h3;
    bus.op_b        = 32'd20;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", bus.out_valid); end
    if (bus.result !== 32'd0)   begin errors++; $display("FAIL rstmid_result got %h exp 0", bus.result); end
    step();
    rst = 1'b0;
    #1;
    checks += 2;
    if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_post_out_valid got %b exp 0", bus.out_valid); end
    run_op(ALU_ADD, 32'd2, 32'd3, lat, res, ill, z, acc_ok, busy_ok, drop_ok);
    checks += 2;
    if (res !== 32'd5) begin errors++; $display("FAIL rstmid_add result got %h exp 5", res); end
    if (lat !== 1)     begin errors++; $display("FAIL rstmid_add latency got %0d exp 1", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
